// File: rtl/mc_fifo_pkg.sv
// Shared width helpers for the multi-channel stream FIFO.
// Pointer/count typedefs are declared in the modules from these helpers.
package mc_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int ptr_w(input int depth);
        return clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth, input int out_reg);
        return clog2(depth + out_reg + 1);
    endfunction

endpackage

// File: rtl/mc_fifo_chan.sv
// One circular FIFO channel with flush, almost-full and optional output slot.
// Latency: 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), one pop per cycle sustained.
// Backpressure: wr_ready drops only on a full memory; pop never opens a slot in the same cycle.
module mc_fifo_chan
    import mc_fifo_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int AFULL_TH   = 3,
    parameter int OUT_REG    = 0
) (
    input  logic                                clk,
    input  logic                                arst_n,
    input  logic                                flush,
    input  logic                                wr_valid,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    output logic                                wr_ready,
    output logic                                rd_valid,
    output logic [DATA_WIDTH-1:0]               rd_data,
    input  logic                                rd_ready,
    output logic [cnt_w(DEPTH, OUT_REG)-1:0]    count,
    output logic                                almost_full
);

    localparam int PTR_W  = ptr_w(DEPTH);
    localparam int MCNT_W = cnt_w(DEPTH, 0);
    localparam int CNT_W  = cnt_w(DEPTH, OUT_REG);

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [MCNT_W-1:0] mcnt_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ptr_t  rd_pt;
    ptr_t  wr_pt;
    mcnt_t mem_cnt;
    logic  mem_empty;
    logic  push;
    logic  pop_mem;

    function automatic ptr_t next_pt(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    assign mem_empty = (mem_cnt == '0);
    assign wr_ready  = (mem_cnt != mcnt_t'(DEPTH));
    assign push      = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rd_pt   <= '0;
            wr_pt   <= '0;
            mem_cnt <= '0;
        end else if (flush) begin
            rd_pt   <= '0;
            wr_pt   <= '0;
            mem_cnt <= '0;
        end else begin
            if (push)    wr_pt <= next_pt(wr_pt);
            if (pop_mem) rd_pt <= next_pt(rd_pt);
            case ({push, pop_mem})
                2'b10:   mem_cnt <= mem_cnt + 1'b1;
                2'b01:   mem_cnt <= mem_cnt - 1'b1;
                default: mem_cnt <= mem_cnt;
            endcase
        end
    end

    // Storage carries no reset; only the bookkeeping above decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_pt] <= wr_data;
    end

    if (OUT_REG == 0) begin : g_fwft
        assign rd_valid = !mem_empty;
        assign rd_data  = rd_valid ? mem[rd_pt] : '0;
        assign pop_mem  = rd_valid && rd_ready;
        assign count    = cnt_t'(mem_cnt);
    end else begin : g_oreg
        logic                  slot_vld;
        logic [DATA_WIDTH-1:0] slot_dat;
        logic                  load;

        // Refill on the same edge the slot is drained to keep one pop per cycle.
        assign load    = !mem_empty && (!slot_vld || rd_ready);
        assign pop_mem = load;

        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                slot_vld <= 1'b0;
                slot_dat <= '0;
            end else if (flush) begin
                slot_vld <= 1'b0;
            end else if (load) begin
                slot_vld <= 1'b1;
                slot_dat <= mem[rd_pt];
            end else if (rd_ready) begin
                slot_vld <= 1'b0;
            end
        end

        assign rd_valid = slot_vld;
        assign rd_data  = slot_dat;
        assign count    = cnt_t'(mem_cnt) + cnt_t'(slot_vld);
    end

    assign almost_full = (count >= cnt_t'(AFULL_TH));

endmodule

// File: rtl/mc_stream_fifo.sv
// Multi-channel lane buffer: NUM_CH independent FIFO channels between vector lanes and SMU.
// Latency: 1 cycle FWFT, 2 cycles with OUT_REG=1.
// Backpressure: per-channel wr_ready from memory fullness only; channels never interact.
module mc_stream_fifo
    import mc_fifo_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int AFULL_TH   = 3,
    parameter int OUT_REG    = 0
) (
    input  logic                                           clk,
    input  logic                                           arst_n,
    input  logic [NUM_CH-1:0]                              flush_i,
    input  logic [NUM_CH-1:0]                              wr_valid_i,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]              wr_data_i,
    output logic [NUM_CH-1:0]                              wr_ready_o,
    output logic [NUM_CH-1:0]                              rd_valid_o,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]              rd_data_o,
    input  logic [NUM_CH-1:0]                              rd_ready_i,
    output logic [NUM_CH-1:0][cnt_w(DEPTH, OUT_REG)-1:0]   count_o,
    output logic [NUM_CH-1:0]                              almost_full_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        mc_fifo_chan #(
            .DEPTH      (DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .AFULL_TH   (AFULL_TH),
            .OUT_REG    (OUT_REG)
        ) u_chan (
            .clk         (clk),
            .arst_n      (arst_n),
            .flush       (flush_i[c]),
            .wr_valid    (wr_valid_i[c]),
            .wr_data     (wr_data_i[c]),
            .wr_ready    (wr_ready_o[c]),
            .rd_valid    (rd_valid_o[c]),
            .rd_data     (rd_data_o[c]),
            .rd_ready    (rd_ready_i[c]),
            .count       (count_o[c]),
            .almost_full (almost_full_o[c])
        );
    end

endmodule
